// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller.
// Computes diff = a - b one bit per clock, LSB first, through a single
// 1-bit subtract cell (two half-subtractors plus a borrow register).
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; last result held on diff/borrow_out
//   BUSY  | one operand bit processed per edge, WIDTH edges in total
//   DONE  | done pulse cycle; diff/borrow_out valid
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             borrow;

    logic ai;
    logic bi;
    logic d;
    logic bout;

    // Shared 1-bit full-subtract cell fed by the operand LSBs and the borrow register
    assign ai   = a_sr[0];
    assign bi   = b_sr[0];
    assign d    = ai ^ bi ^ borrow;
    assign bout = (~ai & bi) | (~(ai ^ bi) & borrow);

    // Sequencer: operand capture, per-bit shifting, borrow chaining and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            cnt        <= '0;
            borrow     <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at diff[0]
                    diff   <= {d, diff[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= bout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        borrow_out <= bout;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed testbench for serial_sub_ctrl (WIDTH = 8).
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int checks   = 0;
    int failures = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation from IDLE; operands are scrambled right after capture.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [7:0] ed, input logic eb, input string tag);
        int n;
        int busy_n;
        bit seen;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ta; b = ~tb_v;
        busy_n = 0; seen = 0; n = 0;
        if (busy) busy_n++;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1;
            else if (busy) busy_n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_busy_cycles"}, busy_n, 8);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow_out, eb);
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, done, 0);
    endtask

    initial begin
        int k;
        int k1;
        int k2;
        int done_n;
        logic [7:0] ra;
        logic [7:0] rb;

        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
        @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_diff", diff, 0);
        chk("reset_borrow", borrow_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic and borrowing cases
        do_op(8'd10, 8'd3, 8'h07, 1'b0, "t1_10m3");
        do_op(8'd3, 8'd10, 8'hF9, 1'b1, "t2_3m10");
        repeat (3) @(posedge clk);
        #1;
        chk("t2_hold_diff", diff, 8'hF9);
        chk("t2_hold_borrow", borrow_out, 1);

        // Edge operands
        do_op(8'h00, 8'h00, 8'h00, 1'b0, "t3_0m0");
        do_op(8'hFF, 8'hFF, 8'h00, 1'b0, "t3_ffmff");
        do_op(8'h00, 8'h01, 8'hFF, 1'b1, "t3_0m1");
        do_op(8'h80, 8'h01, 8'h7F, 1'b0, "t3_80m1");

        // Start held high: back-to-back ops every 10 cycles, mid-op operand changes ignored
        @(negedge clk);
        a = 8'd20; b = 8'd5; start = 1'b1;
        @(posedge clk);
        #1;
        k = 0; k1 = 0; k2 = 0; done_n = 0;
        while (k2 == 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 2)  begin a = 8'd100; b = 8'd1; end
            if (k == 12) begin a = 8'd0;   b = 8'hFF; end
            if (done) begin
                done_n++;
                if (k1 == 0) begin
                    k1 = k;
                    chk("t4_op1_diff", diff, 8'd15);
                    chk("t4_op1_borrow", borrow_out, 0);
                end else begin
                    k2 = k;
                    chk("t4_op2_diff", diff, 8'd99);
                    chk("t4_op2_borrow", borrow_out, 0);
                end
            end
        end
        chk("t4_first_done", k1, 8);
        chk("t4_done_period", k2 - k1, 10);
        chk("t4_done_count", done_n, 2);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_idle_busy", busy, 0);

        // Asynchronous reset in the middle of BUSY
        @(negedge clk);
        a = 8'd10; b = 8'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("t5_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_diff", diff, 0);
        chk("t5_rst_borrow", borrow_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) done_n++;
        end
        chk("t5_no_done", done_n, 0);
        do_op(8'd200, 8'd55, 8'd145, 1'b0, "t5_fresh");

        // Random operands against a - b and a < b
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, ra - rb, (ra < rb), "t6_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
